// File: rtl/time_display_mux.sv
// Six-digit multiplexed 7-segment driver for clock/stopwatch/timer with edit and alarm blinking.
// Outputs registered (one cycle behind digit_idx); content frozen per frame. Option: LEADING_ZERO_BLANK_EN.
module time_display_mux #(
  parameter int SCAN_DIV   = 4,
  parameter int BLINK_HALF = 250
) (
  input  logic       clk_1kHz,
  input  logic       reset,
  input  logic [1:0] mode_sel,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [4:0] stopwatch_hours,
  input  logic [5:0] stopwatch_minutes,
  input  logic [5:0] stopwatch_seconds,
  input  logic [4:0] timer_hours,
  input  logic [5:0] timer_minutes,
  input  logic [5:0] timer_seconds,
  input  logic       set_time_mode,
  input  logic       set_timer_mode,
  input  logic       timer_done,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_STOPWATCH = 2'd1,
    MODE_TIMER     = 2'd2,
    MODE_BLANK     = 2'd3
  } mode_e;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       digit_idx_q, digit_idx_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  mode_e            snap_mode_q, snap_mode_d;
  logic [4:0]       snap_h_q, snap_h_d;
  logic [5:0]       snap_m_q, snap_m_d;
  logic [5:0]       snap_s_q, snap_s_d;
  logic             snap_set_time_q, snap_set_time_d;
  logic             snap_set_timer_q, snap_set_timer_d;
  logic             snap_done_q, snap_done_d;
  logic [5:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic       frame_end;
  logic [3:0] digit_val;
  logic       blink_blank;
  logic       lead_blank;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  always_comb begin
    div_cnt_d        = div_cnt_q;
    digit_idx_d      = digit_idx_q;
    blink_cnt_d      = blink_cnt_q;
    blink_phase_d    = blink_phase_q;
    snap_mode_d      = snap_mode_q;
    snap_h_d         = snap_h_q;
    snap_m_d         = snap_m_q;
    snap_s_d         = snap_s_q;
    snap_set_time_d  = snap_set_time_q;
    snap_set_timer_d = snap_set_timer_q;
    snap_done_d      = snap_done_q;
    frame_end        = (div_cnt_q == DIV_LAST) && (digit_idx_q == 3'd5);

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d   = '0;
      digit_idx_d = (digit_idx_q == 3'd5) ? 3'd0 : digit_idx_q + 3'd1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLK_W'(1);
    end

    // Whole frame is taken from one snapshot so digits never mix two sources or two times.
    if (frame_end) begin
      snap_mode_d      = mode_e'(mode_sel);
      snap_set_time_d  = set_time_mode;
      snap_set_timer_d = set_timer_mode;
      snap_done_d      = timer_done;
      case (mode_sel)
        2'd1: begin
          snap_h_d = stopwatch_hours;
          snap_m_d = stopwatch_minutes;
          snap_s_d = stopwatch_seconds;
        end
        2'd2: begin
          snap_h_d = timer_hours;
          snap_m_d = timer_minutes;
          snap_s_d = timer_seconds;
        end
        default: begin
          snap_h_d = hours;
          snap_m_d = minutes;
          snap_s_d = seconds;
        end
      endcase
    end

    case (digit_idx_q)
      3'd0:    digit_val = ones_of(snap_s_q);
      3'd1:    digit_val = tens_of(snap_s_q);
      3'd2:    digit_val = ones_of(snap_m_q);
      3'd3:    digit_val = tens_of(snap_m_q);
      3'd4:    digit_val = ones_of({1'b0, snap_h_q});
      default: digit_val = tens_of({1'b0, snap_h_q});
    endcase

    blink_blank = blink_phase_q &&
                  (((snap_mode_q == MODE_CLOCK) && snap_set_time_q && (digit_idx_q >= 3'd2)) ||
                   ((snap_mode_q == MODE_TIMER) && (snap_set_timer_q || snap_done_q)));
`ifdef LEADING_ZERO_BLANK_EN
    lead_blank = (digit_idx_q == 3'd5) && (digit_val == 4'd0);
`else
    lead_blank = 1'b0;
`endif

    an_d  = ~(6'b000001 << digit_idx_q);
    dp_d  = !((digit_idx_q == 3'd2) || (digit_idx_q == 3'd4));
    seg_d = (blink_blank || lead_blank) ? SEG_BLANK : seg_of(digit_val);
    if (snap_mode_q == MODE_BLANK) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_1kHz) begin
    if (reset) begin
      div_cnt_q        <= '0;
      digit_idx_q      <= 3'd0;
      blink_cnt_q      <= '0;
      blink_phase_q    <= 1'b0;
      snap_mode_q      <= MODE_CLOCK;
      snap_h_q         <= 5'd0;
      snap_m_q         <= 6'd0;
      snap_s_q         <= 6'd0;
      snap_set_time_q  <= 1'b0;
      snap_set_timer_q <= 1'b0;
      snap_done_q      <= 1'b0;
      an_q             <= 6'b111110;
      seg_q            <= 7'h40;
      dp_q             <= 1'b1;
    end else begin
      div_cnt_q        <= div_cnt_d;
      digit_idx_q      <= digit_idx_d;
      blink_cnt_q      <= blink_cnt_d;
      blink_phase_q    <= blink_phase_d;
      snap_mode_q      <= snap_mode_d;
      snap_h_q         <= snap_h_d;
      snap_m_q         <= snap_m_d;
      snap_s_q         <= snap_s_d;
      snap_set_time_q  <= snap_set_time_d;
      snap_set_timer_q <= snap_set_timer_d;
      snap_done_q      <= snap_done_d;
      an_q             <= an_d;
      seg_q            <= seg_d;
      dp_q             <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_mux.sv
// Directed bench for time_display_mux with SCAN_DIV=2, BLINK_HALF=4.
// k counts edges since reset release: output after edge k shows digit ((k-1)/2)%6 and blink phase ((k-1)/4)%2.
module tb_time_display_mux;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S9 = 7'h10, SB = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HT0 = 7'h7F;
`else
  localparam logic [6:0] HT0 = 7'h40;
`endif

  logic       clk_1kHz = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode_sel = 2'd0;
  logic [4:0] hours = 5'd0, stopwatch_hours = 5'd0, timer_hours = 5'd0;
  logic [5:0] minutes = 6'd0, seconds = 6'd0;
  logic [5:0] stopwatch_minutes = 6'd0, stopwatch_seconds = 6'd0;
  logic [5:0] timer_minutes = 6'd0, timer_seconds = 6'd0;
  logic       set_time_mode = 1'b0, set_timer_mode = 1'b0, timer_done = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [5:0] an_tab [6] = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};

  time_display_mux #(.SCAN_DIV(2), .BLINK_HALF(4)) dut (
    .clk_1kHz(clk_1kHz), .reset(reset), .mode_sel(mode_sel),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .stopwatch_hours(stopwatch_hours), .stopwatch_minutes(stopwatch_minutes),
    .stopwatch_seconds(stopwatch_seconds),
    .timer_hours(timer_hours), .timer_minutes(timer_minutes), .timer_seconds(timer_seconds),
    .set_time_mode(set_time_mode), .set_timer_mode(set_timer_mode), .timer_done(timer_done),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  task automatic step();
    @(posedge clk_1kHz);
    #1;
    k++;
  endtask

  function automatic int dig();
    return ((k - 1) / 2) % 6;
  endfunction

  function automatic logic ph();
    return (((k - 1) / 4) % 2) == 1;
  endfunction

  task automatic test_reset();
    step();
    step();
    checks++; if (an !== 6'b111110) begin errors++; $display("FAIL reset_an: got %b want 111110", an); end
    checks++; if (seg !== 7'h40) begin errors++; $display("FAIL reset_seg: got %h want 40", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", dp); end
    reset = 1'b0;
    k = 0;
  endtask

  task automatic test_scan(input string tag);
    int d;
    logic [6:0] e;
    for (int i = 0; i < 6; i++) begin
      step();
      d = dig();
      e = (d == 5) ? HT0 : S0;
      checks++; if (an !== an_tab[d]) begin errors++; $display("FAIL %s_an k=%0d: got %b want %b", tag, k, an, an_tab[d]); end
      checks++; if (seg !== e) begin errors++; $display("FAIL %s_seg k=%0d: got %h want %h", tag, k, seg, e); end
      checks++; if (dp !== ((d == 2 || d == 4) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL %s_dp k=%0d: got %b", tag, k, dp); end
    end
  endtask

  // Entered mid-frame: 6 steps still show the old frame, then 18 steps of the new content.
  task automatic test_clock();
    logic [6:0] prv [6];
    logic [6:0] cur [6];
    int d;
    logic [6:0] e;
    prv = '{S0, S0, S0, S0, S0, HT0};
    cur = '{S7, S0, S5, S4, S3, S1};
    mode_sel = 2'd0; hours = 5'd13; minutes = 6'd45; seconds = 6'd7;
    for (int i = 0; i < 24; i++) begin
      step();
      d = dig();
      e = (i < 6) ? prv[d] : cur[d];
      checks++; if (an !== an_tab[d]) begin errors++; $display("FAIL clock_an k=%0d: got %b want %b", k, an, an_tab[d]); end
      checks++; if (seg !== e) begin errors++; $display("FAIL clock_seg k=%0d: got %h want %h", k, seg, e); end
      checks++; if (dp !== ((d == 2 || d == 4) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL clock_dp k=%0d: got %b", k, dp); end
    end
  endtask

  task automatic test_stopwatch();
    logic [6:0] prv [6];
    logic [6:0] cur [6];
    int d;
    logic [6:0] e;
    prv = '{S7, S0, S5, S4, S3, S1};
    cur = '{S9, S5, S2, S0, S0, HT0};
    mode_sel = 2'd1; stopwatch_hours = 5'd0; stopwatch_minutes = 6'd2; stopwatch_seconds = 6'd59;
    for (int i = 0; i < 24; i++) begin
      step();
      d = dig();
      e = (i < 6) ? prv[d] : cur[d];
      checks++; if (an !== an_tab[d]) begin errors++; $display("FAIL sw_an k=%0d: got %b want %b", k, an, an_tab[d]); end
      checks++; if (seg !== e) begin errors++; $display("FAIL sw_seg k=%0d: got %h want %h", k, seg, e); end
      checks++; if (dp !== ((d == 2 || d == 4) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL sw_dp k=%0d: got %b", k, dp); end
    end
  endtask

  task automatic test_set_time_blink();
    logic [6:0] prv [6];
    logic [6:0] cur [6];
    int d;
    logic [6:0] e;
    prv = '{S9, S5, S2, S0, S0, HT0};
    cur = '{S7, S0, S5, S4, S3, S1};
    mode_sel = 2'd0; set_time_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      d = dig();
      if (i < 6) e = prv[d];
      else e = (d >= 2 && ph()) ? SB : cur[d];
      checks++; if (an !== an_tab[d]) begin errors++; $display("FAIL settime_an k=%0d: got %b want %b", k, an, an_tab[d]); end
      checks++; if (seg !== e) begin errors++; $display("FAIL settime_seg k=%0d: got %h want %h", k, seg, e); end
      checks++; if (dp !== ((d == 2 || d == 4) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL settime_dp k=%0d: got %b", k, dp); end
    end
  endtask

  task automatic test_timer_done_blink();
    logic [6:0] prv [6];
    logic [6:0] cur [6];
    int d;
    logic [6:0] e;
    prv = '{S7, S0, S5, S4, S3, S1};
    cur = '{S5, S4, S3, S2, S1, HT0};
    mode_sel = 2'd2; set_time_mode = 1'b0; timer_done = 1'b1;
    timer_hours = 5'd1; timer_minutes = 6'd23; timer_seconds = 6'd45;
    for (int i = 0; i < 24; i++) begin
      step();
      d = dig();
      if (i < 6) e = (d >= 2 && ph()) ? SB : prv[d];
      else e = ph() ? SB : cur[d];
      checks++; if (an !== an_tab[d]) begin errors++; $display("FAIL timer_an k=%0d: got %b want %b", k, an, an_tab[d]); end
      checks++; if (seg !== e) begin errors++; $display("FAIL timer_seg k=%0d: got %h want %h", k, seg, e); end
      checks++; if (dp !== ((d == 2 || d == 4) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL timer_dp k=%0d: got %b", k, dp); end
    end
  endtask

  task automatic test_blank_mode();
    logic [6:0] prv [6];
    int d;
    logic [6:0] e;
    logic de;
    prv = '{S5, S4, S3, S2, S1, HT0};
    mode_sel = 2'd3;
    for (int i = 0; i < 24; i++) begin
      step();
      d = dig();
      if (i < 6) begin
        e = ph() ? SB : prv[d];
        de = (d == 2 || d == 4) ? 1'b0 : 1'b1;
      end else begin
        e = SB;
        de = 1'b1;
      end
      checks++; if (an !== an_tab[d]) begin errors++; $display("FAIL blank_an k=%0d: got %b want %b", k, an, an_tab[d]); end
      checks++; if (seg !== e) begin errors++; $display("FAIL blank_seg k=%0d: got %h want %h", k, seg, e); end
      checks++; if (dp !== de) begin errors++; $display("FAIL blank_dp k=%0d: got %b want %b", k, dp, de); end
    end
  endtask

  // Reset in the middle of a frame; the snapshot must be cleared, not reloaded from the inputs.
  task automatic test_reset_midframe();
    mode_sel = 2'd0; timer_done = 1'b0;
    hours = 5'd31; minutes = 6'd63; seconds = 6'd60;
    reset = 1'b1;
    step();
    checks++; if (an !== 6'b111110) begin errors++; $display("FAIL midreset_an: got %b want 111110", an); end
    checks++; if (seg !== 7'h40) begin errors++; $display("FAIL midreset_seg: got %h want 40", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL midreset_dp: got %b want 1", dp); end
    reset = 1'b0;
    k = 0;
    test_scan("postreset");
  endtask

  task automatic test_overflow();
    logic [6:0] prv [6];
    logic [6:0] cur [6];
    int d;
    logic [6:0] e;
    prv = '{S0, S0, S0, S0, S0, HT0};
    cur = '{S0, S6, S3, S6, S1, S3};
    for (int i = 0; i < 24; i++) begin
      step();
      d = dig();
      e = (i < 6) ? prv[d] : cur[d];
      checks++; if (an !== an_tab[d]) begin errors++; $display("FAIL ovf_an k=%0d: got %b want %b", k, an, an_tab[d]); end
      checks++; if (seg !== e) begin errors++; $display("FAIL ovf_seg k=%0d: got %h want %h", k, seg, e); end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] prv [6];
    logic [6:0] cur [6];
    int d;
    logic [6:0] e;
    prv = '{S0, S6, S3, S6, S1, S3};
    cur = '{S0, S0, S0, S0, S5, HT0};
    hours = 5'd5; minutes = 6'd0; seconds = 6'd0;
    for (int i = 0; i < 24; i++) begin
      step();
      d = dig();
      e = (i < 6) ? prv[d] : cur[d];
      checks++; if (seg !== e) begin errors++; $display("FAIL lz_seg k=%0d digit=%0d: got %h want %h", k, d, seg, e); end
    end
  endtask

  initial begin
    test_reset();
    test_scan("scan");
    test_clock();
    test_stopwatch();
    test_set_time_blink();
    test_timer_done_blink();
    test_blank_mode();
    test_reset_midframe();
    test_overflow();
    test_leading_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
